// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   uart_state_e : receiver FSM states
//   calc_div()   : clock divisor for one oversample tick, rounded to nearest
//   IDLE_LEVEL   : idle (mark) level of the serial line
// Optional parity support in uart_rx is enabled with UART_RX_PARITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_state_e;

  localparam logic IDLE_LEVEL = 1'b1;

  // round(clk_freq / (baud * os)) in integer arithmetic
  function automatic int calc_div(input int clk_freq, input int baud, input int os);
    return (clk_freq + (baud * os) / 2) / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider producing a one-cycle tick every DIV
// clocks. i_phase_rst restarts the count from 0 so the tick phase can be
// aligned to an external event (a start-bit edge on the receive side).
//   clk_in      : clock
//   reset_n     : async active-low reset
//   i_phase_rst : synchronous restart of the divider
//   o_tick      : one-cycle tick at counter wrap
// Used by uart_rx (UART_RX_PARITY_EN has no effect here).
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk_in,
  input  logic reset_n,
  input  logic i_phase_rst,
  output logic o_tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n)                        r_cnt <= '0;
    else if (i_phase_rst || r_cnt == LAST) r_cnt <= '0;
    else                                 r_cnt <= r_cnt + 1'b1;
  end

  // A restart cycle never ticks, so the first tick lands a full DIV later.
  assign o_tick = (r_cnt == LAST) && !i_phase_rst;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver with OVERSAMPLE-times oversampling and 3-sample
// majority vote per bit. Delivers each good byte as a one-cycle strobe.
//   clk_in        : clock
//   reset_n       : async active-low reset
//   uart_rx_path  : serial line, idles high, asynchronous
//   rx_data       : last good byte, held until the next good byte
//   rx_valid      : one-cycle strobe when rx_data updates
//   rx_frame_err  : one-cycle strobe on a bad stop bit
//   rx_parity_err : one-cycle strobe on a parity mismatch (0 without parity)
//   rx_busy       : high while a frame is in progress
// Build option: define UART_RX_PARITY_EN for one parity bit after the data
// (PARITY_ODD selects odd parity); otherwise the frame is 8N1.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                 clk_in,
  input  logic                 reset_n,
  input  logic                 uart_rx_path,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_busy
);

  localparam int            DIV    = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int            SW     = $clog2(OVERSAMPLE);
  localparam int            BW     = $clog2(DATA_BITS);
  localparam logic [SW-1:0] S_V0   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_V1   = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_V2   = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_END  = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  logic                 r_sync1, r_sync2, r_line_d;
  uart_state_e          r_state;
  logic [SW-1:0]        r_samp;
  logic [BW-1:0]        r_bitcnt;
  logic [1:0]           r_votes;
  logic [DATA_BITS-1:0] r_shift, r_data;
  logic                 r_valid, r_ferr, r_perr;

  logic w_tick, w_fall, w_start, w_vote_pt, w_end_pt, w_maj, w_par_bad;

`ifdef UART_RX_PARITY_EN
  logic r_par_bad;
  assign w_par_bad = r_par_bad;
`else
  assign w_par_bad = 1'b0;
`endif

  // Two-flop synchroniser plus one delayed copy for edge detection.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1  <= IDLE_LEVEL;
      r_sync2  <= IDLE_LEVEL;
      r_line_d <= IDLE_LEVEL;
    end else begin
      r_sync1  <= uart_rx_path;
      r_sync2  <= r_sync1;
      r_line_d <= r_sync2;
    end
  end

  assign w_fall  = r_line_d & ~r_sync2;
  assign w_start = (r_state == IDLE) && w_fall;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk_in      (clk_in),
    .reset_n     (reset_n),
    .i_phase_rst (w_start),
    .o_tick      (w_tick)
  );

  // The third sample is taken live at the vote point; the first two are stored.
  assign w_vote_pt = w_tick && (r_samp == S_V2);
  assign w_end_pt  = w_tick && (r_samp == S_END);
  assign w_maj     = (r_votes[0] & r_votes[1]) | (r_votes[0] & r_sync2) |
                     (r_votes[1] & r_sync2);

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_samp   <= '0;
      r_bitcnt <= '0;
      r_votes  <= '0;
      r_shift  <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_ferr   <= 1'b0;
      r_perr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_perr  <= 1'b0;

      // Sample index within the current bit; OVERSAMPLE need not be a power of 2.
      if (w_start)     r_samp <= '0;
      else if (w_tick) r_samp <= (r_samp == S_END) ? '0 : r_samp + 1'b1;

      if (w_tick && r_samp == S_V0) r_votes[0] <= r_sync2;
      if (w_tick && r_samp == S_V1) r_votes[1] <= r_sync2;

      case (r_state)
        IDLE: if (w_start) r_state <= START;

        START: begin
          if (w_vote_pt && w_maj) r_state <= IDLE;  // glitch, not a start bit
          else if (w_end_pt) begin
            r_state  <= DATA;
            r_bitcnt <= '0;
          end
        end

        DATA: begin
          if (w_vote_pt) r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
          if (w_end_pt) begin
            if (r_bitcnt == B_LAST) begin
`ifdef UART_RX_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
            end else begin
              r_bitcnt <= r_bitcnt + 1'b1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (w_vote_pt) r_par_bad <= w_maj != ((^r_shift) ^ PARITY_ODD);
          if (w_end_pt)  r_state   <= STOP;
        end
`endif

        // Leave at the vote point so the next start edge is never missed.
        STOP: begin
          if (w_vote_pt) begin
            if (w_maj) begin
              r_state <= IDLE;
              if (w_par_bad) r_perr <= 1'b1;
              else begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
              end
            end else begin
              r_ferr  <= 1'b1;
              r_perr  <= w_par_bad;
              r_state <= BREAK;
            end
          end
        end

        // Hold here while the line is low so a break reports only once.
        BREAK: if (r_sync2 == IDLE_LEVEL) r_state <= IDLE;

        default: r_state <= IDLE;
      endcase
    end
  end

  assign rx_data       = r_data;
  assign rx_valid      = r_valid;
  assign rx_frame_err  = r_ferr;
  assign rx_parity_err = r_perr;
  assign rx_busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at 50 MHz / 115200 baud.
// Table-driven frames, random frames against a rule-based model, and
// hand-written sequences for back-to-back, break, glitch and mid-frame reset.
// Parity cases are included when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

  localparam int CLK_FREQ = 50000000;
  localparam int BAUD     = 115200;
  localparam int OS       = 16;
  localparam int BIT_CYC  = ((CLK_FREQ + (BAUD * OS) / 2) / (BAUD * OS)) * OS;
  localparam bit PAR_ODD  = 1'b0;

  logic       clk_in = 1'b0;
  logic       reset_n = 1'b0;
  logic       uart_rx_path = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, rx_frame_err, rx_parity_err, rx_busy;

  int n_checks = 0, n_fail = 0;
  int n_valid = 0, n_ferr = 0, n_perr = 0, n_both = 0, n_busy = 0, n_hold_bad = 0;
  logic [7:0] q_got[$];
  logic [7:0] prev_data = 8'h00;
  logic [7:0] last_good = 8'h00;

  typedef struct {
    logic [7:0] b;
    bit         stop;
    bit         flip;
    bit         ev;
    bit         efe;
    bit         epe;
    logic [7:0] ed;
  } vec_t;
  vec_t tbl[3];

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8)) dut (
    .clk_in        (clk_in),
    .reset_n       (reset_n),
    .uart_rx_path  (uart_rx_path),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_frame_err  (rx_frame_err),
    .rx_parity_err (rx_parity_err),
    .rx_busy       (rx_busy)
  );

  always #10 clk_in = ~clk_in;

  // Monitor: counts strobe cycles and flags rx_data changing without rx_valid.
  always @(negedge clk_in) begin
    if (reset_n) begin
      if (rx_valid) begin
        n_valid++;
        q_got.push_back(rx_data);
      end else if (rx_data !== prev_data) n_hold_bad++;
      if (rx_frame_err) n_ferr++;
      if (rx_parity_err) n_perr++;
      if (rx_frame_err && rx_parity_err) n_both++;
      if (rx_busy) n_busy++;
    end
    prev_data = rx_data;
  end

  initial begin
    repeat (120000) @(posedge clk_in);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic settle();
    @(negedge clk_in);
    #1;
  endtask

  task automatic hold(input bit v, input int cyc);
    @(posedge clk_in);
    #2 uart_rx_path = v;
    repeat (cyc - 1) @(posedge clk_in);
  endtask

  // Start bit, data LSB first, and parity bit when enabled (flip corrupts it).
  task automatic send_bits(input logic [7:0] b, input bit flip);
    hold(1'b0, BIT_CYC);
    for (int i = 0; i < 8; i++) hold(b[i], BIT_CYC);
`ifdef UART_RX_PARITY_EN
    hold((^b) ^ PAR_ODD ^ flip, BIT_CYC);
`endif
  endtask

  // Reference rules: bad stop -> frame error; bad parity -> parity error;
  // only a fully good frame produces a byte.
  function automatic void model(input logic [7:0] b, input bit stop, input bit flip,
                                output bit ev, output bit efe, output bit epe,
                                output logic [7:0] ed);
    bit par_ok;
`ifdef UART_RX_PARITY_EN
    par_ok = !flip;
`else
    par_ok = 1'b1;
`endif
    efe = !stop;
    epe = !par_ok;
    ev  = stop && par_ok;
    ed  = ev ? b : last_good;
  endfunction

  task automatic run_frame(input string tag, input logic [7:0] b, input bit stop,
                           input bit flip, input bit ev, input bit efe, input bit epe,
                           input logic [7:0] ed);
    int v0, f0, p0;
    logic [8:0] got;
    v0 = n_valid; f0 = n_ferr; p0 = n_perr;
    send_bits(b, flip);
    hold(stop, BIT_CYC);
    hold(1'b1, BIT_CYC);
    settle();
    chk({tag, ".valid"}, n_valid - v0, ev);
    chk({tag, ".ferr"}, n_ferr - f0, efe);
    chk({tag, ".perr"}, n_perr - p0, epe);
    chk({tag, ".data"}, rx_data, ed);
    chk({tag, ".busy"}, rx_busy, 0);
    if (ev) begin
      got = (q_got.size() > 0) ? {1'b0, q_got[q_got.size()-1]} : 9'h100;
      chk({tag, ".strobe_data"}, got, b);
      last_good = b;
    end
  endtask

  initial begin
    bit ev, efe, epe, stop, flip;
    logic [7:0] b, ed, hd;
    int v0, f0, p0, bz0, both0;

    tbl[0] = '{b: 8'h55, stop: 1'b1, flip: 1'b0, ev: 1'b1, efe: 1'b0, epe: 1'b0, ed: 8'h55};
    tbl[1] = '{b: 8'hC9, stop: 1'b0, flip: 1'b0, ev: 1'b0, efe: 1'b1, epe: 1'b0, ed: 8'h55};
    tbl[2] = '{b: 8'h12, stop: 1'b1, flip: 1'b0, ev: 1'b1, efe: 1'b0, epe: 1'b0, ed: 8'h12};

    // Reset state
    repeat (5) @(posedge clk_in);
    settle();
    chk("rst.data", rx_data, 0);
    chk("rst.valid", rx_valid, 0);
    chk("rst.ferr", rx_frame_err, 0);
    chk("rst.perr", rx_parity_err, 0);
    chk("rst.busy", rx_busy, 0);
    @(posedge clk_in);
    #2 reset_n = 1'b1;
    repeat (BIT_CYC) @(posedge clk_in);
    settle();
    chk("idle.busy", rx_busy, 0);

    // Table-driven frames
    for (int i = 0; i < 3; i++)
      run_frame($sformatf("tbl%0d", i), tbl[i].b, tbl[i].stop, tbl[i].flip,
                tbl[i].ev, tbl[i].efe, tbl[i].epe, tbl[i].ed);

    // Random frames against the model
    for (int i = 0; i < 3; i++) begin
      b    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
`ifdef UART_RX_PARITY_EN
      flip = ($urandom_range(0, 3) == 0);
`else
      flip = 1'b0;
`endif
      model(b, stop, flip, ev, efe, epe, ed);
      run_frame($sformatf("rnd%0d", i), b, stop, flip, ev, efe, epe, ed);
    end

    // Back-to-back 0x00 then 0xFF, no idle between frames
    v0 = n_valid;
    send_bits(8'h00, 1'b0);
    hold(1'b1, BIT_CYC);
    send_bits(8'hFF, 1'b0);
    hold(1'b1, BIT_CYC);
    hold(1'b1, BIT_CYC);
    settle();
    chk("b2b.count", n_valid - v0, 2);
    chk("b2b.first", (q_got.size() >= 2) ? {1'b0, q_got[q_got.size()-2]} : 9'h100, 8'h00);
    chk("b2b.second", (q_got.size() >= 1) ? {1'b0, q_got[q_got.size()-1]} : 9'h100, 8'hFF);
    last_good = 8'hFF;

    // 0xA3 with stop low, line held low 100 us
    v0 = n_valid; f0 = n_ferr; p0 = n_perr; hd = last_good;
    send_bits(8'hA3, 1'b0);
    hold(1'b0, BIT_CYC + 5000);
    hold(1'b1, BIT_CYC);
    settle();
    chk("brk.ferr", n_ferr - f0, 1);
    chk("brk.valid", n_valid - v0, 0);
    chk("brk.perr", n_perr - p0, 0);
    chk("brk.data", rx_data, hd);
    chk("brk.busy", rx_busy, 0);
    run_frame("brk.recover", 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C);

    // 1 us glitch on an idle line
    v0 = n_valid; f0 = n_ferr; p0 = n_perr; bz0 = n_busy;
    hold(1'b0, 50);
    hold(1'b1, BIT_CYC);
    settle();
    chk("glitch.busy_seen", (n_busy - bz0) > 0, 1);
    chk("glitch.strobes", (n_valid - v0) + (n_ferr - f0) + (n_perr - p0), 0);
    chk("glitch.idle", rx_busy, 0);
    chk("glitch.data", rx_data, last_good);

    // Reset during bit 3 of 0x81
    hold(1'b0, BIT_CYC);
    hold(1'b1, BIT_CYC);
    hold(1'b0, BIT_CYC);
    hold(1'b0, BIT_CYC);
    hold(1'b0, BIT_CYC / 2);
    settle();
    chk("midrst.busy_before", rx_busy, 1);
    @(posedge clk_in);
    #2;
    reset_n = 1'b0;
    uart_rx_path = 1'b1;
    repeat (50) @(posedge clk_in);
    settle();
    chk("midrst.data", rx_data, 0);
    chk("midrst.valid", rx_valid, 0);
    chk("midrst.ferr", rx_frame_err, 0);
    chk("midrst.perr", rx_parity_err, 0);
    chk("midrst.busy", rx_busy, 0);
    repeat (50) @(posedge clk_in);
    #2 reset_n = 1'b1;
    last_good = 8'h00;
    hold(1'b1, BIT_CYC);
    run_frame("midrst.next", 8'h7E, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h7E);

`ifdef UART_RX_PARITY_EN
    run_frame("par.good", 8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h07);
    run_frame("par.bad", 8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h07);
    both0 = n_both;
    run_frame("par.both", 8'h07, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h07);
    chk("par.both_same_cycle", n_both - both0, 1);
`else
    both0 = n_both;
    chk("noparity.perr_never", n_perr + (n_both - both0), 0);
`endif

    chk("data_hold", n_hold_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
